// File: rtl/clk_en_sched_if.sv
// Divide-ratio configuration handshake between a host and clk_en_sched.
interface clk_en_sched_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_en_sched.sv
// Run-time programmable clock-enable scheduler: tick every N cycles and a
// 2N-period square wave; ratio changes, start and stop land on period edges.
module clk_en_sched #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  clk_en_sched_if.slave    cfg,
  output logic             tick,
  output logic             div_out,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] pend_div;
  logic             pend;

  logic             cfg_ready_c;
  logic             xfer_c;
  logic             wrap_c;
  logic [CNT_W-1:0] cfg_div_c;

  // Handshake decode, period-end detect and zero-ratio clamp.
  always_comb begin
    cfg_ready_c = (state == IDLE) || !pend;
    xfer_c      = cfg.cfg_valid && cfg_ready_c;
    wrap_c      = (cnt == (act_div - CNT_W'(1)));
    cfg_div_c   = (cfg.cfg_div == '0) ? CNT_W'(1) : cfg.cfg_div;
  end

  assign cfg.cfg_ready = cfg_ready_c;
  assign cur_div       = act_div;

  // Scheduler state, counter, ratio registers and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      act_div  <= CNT_W'(DEF_DIV);
      pend_div <= CNT_W'(DEF_DIV);
      pend     <= 1'b0;
      tick     <= 1'b0;
      div_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          tick    <= 1'b0;
          div_out <= 1'b0;
          // A ratio accepted together with run already governs the first period.
          if (xfer_c) act_div <= cfg_div_c;
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (wrap_c) begin
            cnt  <= '0;
            tick <= 1'b1;
            // Only a ratio pending before this edge applies here.
            if (pend) begin
              act_div <= pend_div;
              pend    <= 1'b0;
            end
          end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
          end
          // ready implies !pend here, so this never collides with the apply.
          if (xfer_c) begin
            pend_div <= cfg_div_c;
            pend     <= 1'b1;
          end
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
            if (wrap_c) div_out <= ~div_out;
          end else if ((state == DRAIN) && wrap_c) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_out <= 1'b0;
          end else begin
            state <= DRAIN;
            if (wrap_c) div_out <= ~div_out;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched: vector table plus multi-cycle sequences.
module tb_clk_en_sched;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             run;
  logic             tick;
  logic             div_out;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  clk_en_sched_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_en_sched #(.CNT_W(CNT_W), .DEF_DIV(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .cfg     (cfg_if),
    .tick    (tick),
    .div_out (div_out),
    .busy    (busy),
    .cur_div (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             run;
    logic             cv;
    logic [CNT_W-1:0] cd;
    logic             tick;
    logic             dout;
    logic             busy;
    logic [CNT_W-1:0] cur;
    logic             rdy;
  } vec_t;

  vec_t tbl[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: through the rising edge, then settle to the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    reset            = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic t, input logic d, input logic b,
                            input logic [CNT_W-1:0] c, input logic r);
    chk({tag, " tick"},    32'(tick),             32'(t));
    chk({tag, " div_out"}, 32'(div_out),          32'(d));
    chk({tag, " busy"},    32'(busy),             32'(b));
    chk({tag, " cur_div"}, 32'(cur_div),          32'(c));
    chk({tag, " ready"},   32'(cfg_if.cfg_ready), 32'(r));
  endtask

  initial begin
    // Scenario 1: load 4 in IDLE, then run; ticks after edges 4, 8, 12.
    tbl[0] = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1};
    for (int i = 2; i < 13; i++) begin
      int e;
      logic t;
      e = i - 1;
      t = ((e % 4) == 0);
      tbl[i] = '{1'b1, 1'b0, 8'd0, t, ((e / 4) % 2) == 1, 1'b1, 8'd4, 1'b1};
    end

    do_reset();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);

    for (int i = 0; i < 13; i++) begin
      run              = tbl[i].run;
      cfg_if.cfg_valid = tbl[i].cv;
      cfg_if.cfg_div   = tbl[i].cd;
      cyc();
      check_outs($sformatf("s1 v%0d", i), tbl[i].tick, tbl[i].dout, tbl[i].busy,
                 tbl[i].cur, tbl[i].rdy);
    end

    // Scenario 2: run at 3 (loaded with run), change to 5 mid-period.
    do_reset();
    run = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd3;
    cyc();
    chk("s2 entry cur_div", 32'(cur_div), 32'd3);
    chk("s2 entry busy", 32'(busy), 32'd1);
    for (int e = 1; e <= 17; e++) begin
      cfg_if.cfg_valid = (e == 4);
      cfg_if.cfg_div   = 8'd5;
      cyc();
      chk($sformatf("s2 tick e%0d", e), 32'(tick),
          32'((e == 3) || (e == 6) || (e == 11) || (e == 16)));
      chk($sformatf("s2 ready e%0d", e), 32'(cfg_if.cfg_ready), 32'(!((e == 4) || (e == 5))));
      chk($sformatf("s2 cur_div e%0d", e), 32'(cur_div), (e >= 6) ? 32'd5 : 32'd3);
    end

    // Scenario 3a: run at 6, drop run at cnt=2 in third period; final tick clears div_out.
    do_reset();
    run = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd6;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      run = (e < 15);
      cyc();
      chk($sformatf("s3a tick e%0d", e), 32'(tick), 32'((e == 6) || (e == 12) || (e == 18)));
      chk($sformatf("s3a div_out e%0d", e), 32'(div_out), 32'((e >= 6) && (e < 12)));
      chk($sformatf("s3a busy e%0d", e), 32'(busy), 32'(e < 18));
    end
    chk("s3a cur_div", 32'(cur_div), 32'd6);

    // Scenario 3b: same, but run returns at cnt=4; period stays 6 without glitch.
    do_reset();
    run = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd6;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      run = !((e == 15) || (e == 16));
      cyc();
      chk($sformatf("s3b tick e%0d", e), 32'(tick), 32'((e % 6) == 0));
      chk($sformatf("s3b div_out e%0d", e), 32'(div_out), 32'(((e / 6) % 2) == 1));
      chk($sformatf("s3b busy e%0d", e), 32'(busy), 32'd1);
    end

    // Scenario 4: ratio 0 clamps to 1; tick stays high, div_out toggles each cycle.
    do_reset();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd0;
    cyc();
    chk("s4 cur_div", 32'(cur_div), 32'd1);
    chk("s4 idle busy", 32'(busy), 32'd0);
    cfg_if.cfg_valid = 1'b0; run = 1'b1;
    cyc();
    chk("s4 entry tick", 32'(tick), 32'd0);
    for (int e = 1; e <= 6; e++) begin
      cyc();
      chk($sformatf("s4 tick e%0d", e), 32'(tick), 32'd1);
      chk($sformatf("s4 div_out e%0d", e), 32'(div_out), 32'((e % 2) == 1));
    end

    // Scenario 5: transfer on a wrap edge at N=2; next period still 2, then 7.
    do_reset();
    run = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd2;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      cfg_if.cfg_valid = (e == 4);
      cfg_if.cfg_div   = 8'd7;
      cyc();
      chk($sformatf("s5 tick e%0d", e), 32'(tick),
          32'((e == 2) || (e == 4) || (e == 6) || (e == 13) || (e == 20)));
      chk($sformatf("s5 ready e%0d", e), 32'(cfg_if.cfg_ready), 32'(!((e == 4) || (e == 5))));
      chk($sformatf("s5 cur_div e%0d", e), 32'(cur_div), (e >= 6) ? 32'd7 : 32'd2);
    end

    // Scenario 6: asynchronous reset mid-period at N=5, cnt=3, then restart at DEF_DIV.
    do_reset();
    run = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 8'd5;
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      chk($sformatf("s6 tick e%0d", e), 32'(tick), 32'(e == 5));
    end
    chk("s6 pre div_out", 32'(div_out), 32'd1);
    chk("s6 pre busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_outs("s6 async", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    @(negedge clk);
    check_outs("s6 held", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    reset = 1'b1;
    cyc();
    chk("s6 entry busy", 32'(busy), 32'd1);
    chk("s6 entry tick", 32'(tick), 32'd0);
    for (int e = 1; e <= 6; e++) begin
      cyc();
      chk($sformatf("s6r tick e%0d", e), 32'(tick), 32'((e % 2) == 0));
      chk($sformatf("s6r div_out e%0d", e), 32'(div_out), 32'(((e / 2) % 2) == 1));
      chk($sformatf("s6r cur_div e%0d", e), 32'(cur_div), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_en_sched.md
# clk_en_sched

Run-time programmable clock-enable scheduler for the clock divider family. It counts `clk` cycles and produces a one-cycle `tick` strobe every N cycles plus a square wave `div_out` of period 2N, so downstream logic runs off enables instead of derived clocks. The divide ratio is reconfigured through a valid/ready handshake and is applied only on a period boundary, so no short or long periods appear. Start and stop are sequenced the same way.

## Interface
- `CNT_W`, default 8: width of the divide ratio and of the cycle counter.
- `DEF_DIV`, default 2: divide ratio loaded on reset. Must lie in 1..2^CNT_W-1.
- `clk`, in, 1: the single clock. Everything is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Assertion takes effect immediately. Release is sampled by `clk`.
- `run`, in, 1: level request to run the scheduler.
- `cfg_valid`, in, 1: a new divide ratio is offered.
- `cfg_div`, in, CNT_W: the new ratio. A value of 0 is treated as 1.
- `cfg_ready`, out, 1: block can accept a ratio.
- `tick`, out, 1: registered enable strobe, high for one cycle per period.
- `div_out`, out, 1: registered, toggles on every tick.
- `busy`, out, 1: state is not IDLE.
- `cur_div`, out, CNT_W: the ratio currently in effect.

## Operation
- States: IDLE, RUN, DRAIN.
- Internal registers: `cnt` (CNT_W bits), `act_div`, `pend_div`, `pend` flag.
- **IDLE**
  - `cnt`=0, `tick`=0, `div_out`=0.
  - `run`=1 → RUN, with `cnt`<=0.
- **RUN**
  - "Wrap" means `cnt == act_div-1`.
  - At a wrap: `cnt`<=0, `tick`<=1, `div_out`<=~`div_out`.
  - Otherwise: `cnt`<=`cnt`+1, `tick`<=0.
  - `run`=0 at any edge → DRAIN. Counting continues unchanged.
- **DRAIN**
  - Counts exactly as RUN.
  - At a wrap: emits the final `tick` and goes to IDLE. `div_out`<=0 on that edge, overriding the toggle.
  - `run`=1 before the wrap → back to RUN with no disturbance to `cnt`, `tick` or `div_out`.
- **Config handshake**
  - A transfer happens on an edge where `cfg_valid` and `cfg_ready` are both 1.
  - `cfg_ready` = IDLE or !`pend`.
  - In IDLE, a transfer writes `act_div` directly.
  - In RUN or DRAIN, a transfer writes `pend_div` and sets `pend`.
  - At the next wrap edge after the transfer: `act_div`<=`pend_div` and `pend`<=0. `cfg_ready` returns to 1 in the following cycle.
  - A transfer on a wrap edge is held as pending and applies at the following wrap, not the current one.
  - A pending ratio still left when DRAIN ends is applied on the DRAIN→IDLE edge.
- **Simultaneous events**
  - IDLE, `run`=1 and a transfer on the same edge: the new ratio is in effect for the first period.
  - `cfg_div`=0 is stored as 1.
- **Reset** (asynchronous, any time, including mid-period)
  - State=IDLE, `cnt`=0, `act_div`=DEF_DIV, `pend`=0.
  - `tick`=0, `div_out`=0, `busy`=0, `cur_div`=DEF_DIV.
  - `cfg_ready`=1 while reset is deasserted and IDLE.

## Timing
- The entry edge into RUN is edge 0.
- With ratio N, the first `tick` is high in the cycle after edge N, then again after every N further edges.
- `div_out` period is 2N cycles with 50% duty. It first rises together with the first `tick`.
- N=1: `tick` is held high continuously and `div_out` toggles every cycle.
- A ratio change takes effect for the period that starts at the applying wrap. Every period is exactly the old N or exactly the new N.
- `busy` and `cur_div` are registered and update on the same edge as the state or `act_div` change.
- No combinational path from inputs to outputs except `cfg_ready`, which depends only on state and `pend`.

## Test plan
- Reset, `cfg_div`=4 in IDLE, then `run`=1:
  - `tick` is high 4 cycles after entry, then every 4 cycles.
  - `div_out` has period 8.
  - `cur_div`=4.
- Running at N=3, transfer `cfg_div`=5 mid-period:
  - `cfg_ready` drops the next cycle.
  - The current period stays 3 cycles, then periods are 5.
  - `cfg_ready` returns 1 after the applying wrap.
- Running at N=6, `run`=0 at `cnt`=2:
  - 3 more cycles of counting, one final `tick`.
  - `div_out`=0 and `busy`=0 after the wrap.
  - Repeat with `run` reasserted at `cnt`=4: no glitch, and the period stays 6.
- `cfg_div`=0 in IDLE, then run: `cur_div`=1, `tick` held high, `div_out` toggles every cycle.
- Transfer exactly on a wrap edge at N=2 to 7: the next period is still 2, then 7.
- Assert `reset` asynchronously between edges at N=5, `cnt`=3:
  - All outputs go to their reset values at once, `cur_div`=DEF_DIV.
  - After release with `run` held 1, restart timing matches the first scenario for N=DEF_DIV.
